reset_seq_gen: RTL and testbench

Parametrised reset sequencer for a single clock domain. It synchronises an asynchronous active-low reset and an optional asynchronous PLL-lock input, stretches the release by a programmable hold time, then deasserts N_OUT reset outputs one after another at a fixed step. A synchronous software reset request re-runs the sequence. It sits at the top of each clock domain (pixel, DVI serialiser, LCD bus) and feeds downstream block resets in dependency order.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_seq_gen_bit_sync.sv | 24 ++
 rtl/reset_seq_gen.sv | 134 +++++++++++++
 tb/tb_reset_seq_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding and width helper.
package reset_seq_pkg;

   // Sequencer phases: waiting out the hold time, stepping channels, finished.
   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_STEP = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count up to the larger of the two wait lengths.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_seq_gen_bit_sync.sv
// Multi-stage single-bit synchroniser with asynchronous active-low clear.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   // Shift the input through the chain; clear every stage on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_seq_gen.sv
// Reset sequencer: synchronises reset release and PLL lock, waits a hold
// time, then releases N_OUT active-low resets one at a time.
module reset_seq_gen
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 4,
   parameter int N_OUT       = 3,
   parameter int WAIT_LOCK   = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_lock,
   input  logic             i_sw_rst,
   output logic [N_OUT-1:0] o_rst_n,
   output logic             o_done
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
   localparam int CH_W  = $clog2(N_OUT) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_OUT - 1);

   logic             w_rst_sync;
   logic             w_lock_sync;
   logic             w_ok;
   logic [N_OUT-1:0] w_ch_mask;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CH_W-1:0]  r_ch;
   logic [N_OUT-1:0] r_rst_n;
   logic             r_done;

   bit_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (1'b1),
      .o_q     (w_rst_sync)
   );

   generate
      if (WAIT_LOCK != 0) begin : g_lock
         bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_lock),
            .o_q     (w_lock_sync)
         );
      end else begin : g_no_lock
         // Lock is ignored: the OR keeps the port referenced but forces 1.
         assign w_lock_sync = i_lock | 1'b1;
      end
   endgenerate

   assign w_ok = w_rst_sync & w_lock_sync & ~i_sw_rst;

   // One-hot select of the channel currently being stepped.
   always_comb begin
      w_ch_mask = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (r_ch == CH_W'(i)) begin
            w_ch_mask[i] = 1'b1;
         end else begin
            w_ch_mask[i] = 1'b0;
         end
      end
   end

   // Sequencer FSM: any loss of ok collapses all outputs at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_HOLD;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_rst_n <= '0;
         r_done  <= 1'b0;
      end else if (!w_ok) begin
         r_state <= ST_HOLD;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_rst_n <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt      <= '0;
                  r_rst_n[0] <= 1'b1;
                  if (N_OUT == 1) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_STEP;
                     r_ch    <= CH_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_STEP: begin
               if (r_cnt == STEP_LAST) begin
                  r_cnt   <= '0;
                  r_rst_n <= r_rst_n | w_ch_mask;
                  if (r_ch == CH_LAST) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_ch <= r_ch + CH_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_HOLD;
               r_cnt   <= '0;
               r_ch    <= '0;
               r_rst_n <= '0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rst_n = r_rst_n;
   assign o_done  = r_done;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: default instance plus a minimal
// N_OUT=1 / HOLD_CYCLES=1 / WAIT_LOCK=0 instance.
module tb_reset_seq_gen;

   logic       clk;
   logic       rst_n;
   logic       lock;
   logic       sw_rst;
   logic [2:0] o_rst_n;
   logic       o_done;

   logic       rst1_n;
   logic [0:0] o1_rst_n;
   logic       o1_done;

   int checks;
   int errors;
   int edge_n;

   reset_seq_gen dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_lock   (lock),
      .i_sw_rst (sw_rst),
      .o_rst_n  (o_rst_n),
      .o_done   (o_done)
   );

   reset_seq_gen #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (1),
      .STEP_CYCLES (4),
      .N_OUT       (1),
      .WAIT_LOCK   (0)
   ) dut1 (
      .i_clk    (clk),
      .i_rst_n  (rst1_n),
      .i_lock   (1'b0),
      .i_sw_rst (1'b0),
      .o_rst_n  (o1_rst_n),
      .o_done   (o1_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) tick();
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
   endtask

   task automatic reassert_rst();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      lock   = 1'b1;
      sw_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("reset_rst_n", {5'd0, o_rst_n}, 8'h00);
      chk("reset_done", {7'd0, o_done}, 8'h00);
      chk("reset1_rst_n", {7'd0, o1_rst_n}, 8'h00);

      // Power-up sequence
      release_rst();
      run_to(17); chk("pu_e17", {5'd0, o_rst_n}, 8'h00);
      run_to(18); chk("pu_e18", {5'd0, o_rst_n}, 8'h01);
      run_to(21); chk("pu_e21", {5'd0, o_rst_n}, 8'h01);
      run_to(22); chk("pu_e22", {5'd0, o_rst_n}, 8'h03);
      run_to(25); chk("pu_e25", {5'd0, o_rst_n}, 8'h03);
                  chk("pu_done_e25", {7'd0, o_done}, 8'h00);
      run_to(26); chk("pu_e26", {5'd0, o_rst_n}, 8'h07);
                  chk("pu_done_e26", {7'd0, o_done}, 8'h01);

      // Software reset pulse sampled at edge 40
      run_to(39);
      sw_rst = 1'b1;
      run_to(40); chk("sw_e40", {5'd0, o_rst_n}, 8'h00);
                  chk("sw_done_e40", {7'd0, o_done}, 8'h00);
      sw_rst = 1'b0;
      run_to(55); chk("sw_e55", {5'd0, o_rst_n}, 8'h00);
      run_to(56); chk("sw_e56", {5'd0, o_rst_n}, 8'h01);
      run_to(63); chk("sw_e63", {5'd0, o_rst_n}, 8'h03);
      run_to(64); chk("sw_e64", {5'd0, o_rst_n}, 8'h07);
                  chk("sw_done_e64", {7'd0, o_done}, 8'h01);

      // Lock loss: low first sampled at edge 20, high first sampled at edge 31
      reassert_rst();
      release_rst();
      run_to(19);
      lock = 1'b0;
      run_to(21); chk("lk_e21", {5'd0, o_rst_n}, 8'h01);
      run_to(22); chk("lk_e22", {5'd0, o_rst_n}, 8'h00);
      run_to(30);
      lock = 1'b1;
      run_to(47); chk("lk_e47", {5'd0, o_rst_n}, 8'h00);
      run_to(48); chk("lk_e48", {5'd0, o_rst_n}, 8'h01);

      // Asynchronous reset between edges 23 and 24
      reassert_rst();
      release_rst();
      run_to(23); chk("ar_e23", {5'd0, o_rst_n}, 8'h03);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_async_rst_n", {5'd0, o_rst_n}, 8'h00);
      chk("ar_async_done", {7'd0, o_done}, 8'h00);
      release_rst();
      run_to(17); chk("ar_e17", {5'd0, o_rst_n}, 8'h00);
      run_to(18); chk("ar_e18", {5'd0, o_rst_n}, 8'h01);
      run_to(26); chk("ar_e26", {5'd0, o_rst_n}, 8'h07);
                  chk("ar_done_e26", {7'd0, o_done}, 8'h01);

      // Software reset held for edges 30..39; first low sample at edge 40
      run_to(29);
      sw_rst = 1'b1;
      run_to(30); chk("swh_e30", {5'd0, o_rst_n}, 8'h00);
      run_to(39); chk("swh_e39", {5'd0, o_rst_n}, 8'h00);
                  chk("swh_cnt_e39", {5'd0, dut.r_cnt}, 8'h00);
      sw_rst = 1'b0;
      run_to(40); chk("swh_cnt_e40", {5'd0, dut.r_cnt}, 8'h01);
      run_to(54); chk("swh_e54", {5'd0, o_rst_n}, 8'h00);
      run_to(55); chk("swh_e55", {5'd0, o_rst_n}, 8'h01);

      // Minimal instance: lock ignored, single channel, one-cycle hold
      @(negedge clk);
      rst1_n = 1'b1;
      edge_n = 0;
      run_to(2); chk("p1_e2_rst_n", {7'd0, o1_rst_n}, 8'h00);
                 chk("p1_e2_done", {7'd0, o1_done}, 8'h00);
      run_to(3); chk("p1_e3_rst_n", {7'd0, o1_rst_n}, 8'h01);
                 chk("p1_e3_done", {7'd0, o1_done}, 8'h01);
      run_to(6); chk("p1_e6_hold", {7'd0, o1_rst_n}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
